multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencing FSM for the RvNOVA RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It consumes the control bits produced by the main instruction decoder and drives the enables and selects for the PC, IR, ALU, memory port and register file. It owns the single shared memory port's req/ready handshake, counts retired instructions, and halts on illegal, ECALL or EBREAK instructions until software or the debugger acknowledges.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dec_reg_write  in  1  decoder: result written to register file
dec_mem_read  in  1  decoder: load
dec_mem_write  in  1  decoder: store
dec_mem_to_reg  in  1  decoder: writeback source is memory
dec_branch  in  1  decoder: conditional branch
dec_jump  in  1  decoder: JAL/JALR
dec_illegal  in  1  decoder: opcode not recognised
dec_system  in  1  decoder: ECALL/EBREAK (opcode 11100)
br_taken  in  1  ALU compare result, valid in EXEC
mem_ready  in  1  memory handshake completion
trap_ack  in  1  resume request while halted
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store qualifier for mem_req
mem_addr_sel  out  1  0=PC (fetch), 1=ALU result (data)
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_sel  out  2  00=PC+4, 01=branch/jump target, 10=trap vector
rf_we  out  1  register file write enable
wb_sel  out  2  00=ALU, 01=memory data, 10=PC+4
halted  out  1  controller in TRAP
trap_cause  out  2  00 none, 01 illegal, 10 system
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are combinational from state plus registered flags, except instret, halted and trap_cause, which are registered.
- Reset (async, rst_n=0): state=FETCH; instret=0; halted=0; trap_cause=00; latched flags cleared. All combinational outputs read 0 while reset is asserted; mem_req drops immediately, even mid-transaction.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. In the cycle mem_req&&mem_ready, ir_we=1 and next state is DECODE. Otherwise the state holds with mem_req still high; a request is never withdrawn.
- DECODE: one cycle. Latch all dec_* flags into internal registers.
  - dec_illegal=1 -> TRAP with cause 01.
  - Otherwise dec_system=1 -> TRAP with cause 10.
  - Otherwise -> EXEC.
  - If both are set, illegal wins.
- EXEC: one cycle. Sample br_taken into take_q = jump_q | (branch_q & br_taken).
  - mem_read_q|mem_write_q -> MEM.
  - Otherwise reg_write_q -> WB.
  - Otherwise retire -> FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=mem_write_q. On mem_ready: mem_read_q -> WB, otherwise retire -> FETCH. Hold while not ready.
- WB: one cycle. rf_we=1. wb_sel=01 if mem_to_reg_q, 10 if jump_q, else 00. Retire -> FETCH.
- Retire, in the last cycle of each instruction: pc_we=1; pc_sel=01 if take_q else 00; instret increments by 1 on the following edge, wrapping from all-ones to 0.
  - pc_we pulses exactly once per retired instruction.
  - rf_we pulses at most once per instruction.
- TRAP: halted=1 and trap_cause held; no memory requests. Trapping instructions do not retire (instret unchanged). On trap_ack=1: pc_we=1, pc_sel=10, halted and trap_cause clear next edge, next state FETCH. trap_ack outside TRAP is ignored.
- mem_ready while mem_req=0 is ignored.
- Minimum latencies with zero-wait memory:
  - ALU op / LUI / AUIPC: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles
  - JAL/JALR: 4 cycles
  - Each memory wait state adds 1 cycle.

Decomposition:
- Package rvnova_ctrl_pkg holds:
  - ctrl_state_t enum (FETCH..TRAP)
  - PC_SEL_* and WB_SEL_* encodings
  - TRAP_NONE/ILLEGAL/SYSTEM codes
- One sub-module, instret_counter: CNT_W-bit counter with inc and async clear.

Test Plan:
- R-type (dec_reg_write=1), mem_ready tied 1 -> states FETCH,DECODE,EXEC,WB. rf_we=1 with wb_sel=00 in cycle 4, pc_we with pc_sel=00 in the same cycle; instret 0->1.
- Load with mem_ready delayed 2 cycles in both FETCH and MEM -> mem_req held high 3 cycles each phase, mem_addr_sel 0 then 1, wb_sel=01, total 9 cycles, one rf_we pulse.
- Store then branch taken (br_taken=1) then branch not taken -> store: mem_we=1 in MEM, no rf_we. Branches: pc_sel=01 then 00, 3 cycles each, no mem_req in EXEC; instret=3.
- JAL (dec_jump=1, dec_reg_write=1) -> wb_sel=10, pc_sel=01 at retire.
- dec_illegal=1 with dec_system=1 -> TRAP, trap_cause=01, halted=1, instret unchanged, mem_req stays 0 for 10 cycles. trap_ack -> pc_we with pc_sel=10, then FETCH.
- rst_n asserted mid-MEM with mem_req=1 -> mem_req drops the same cycle (async), instret=0. After release, FETCH resumes. Also: preload instret to all-ones and retire one instruction -> instret=0.

Source files
------------

// File: rtl/rvnova_ctrl_pkg.sv
// Shared types and encodings for the RvNOVA multi-cycle controller.
package rvnova_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } ctrl_state_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_SYSTEM  = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W, cleared by reset.
module instret_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + One;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RvNOVA RV32I core,
// with a TRAP state that halts on illegal/system instructions until acknowledged.
module multicycle_ctrl
  import rvnova_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_mem_to_reg,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_illegal,
  input  logic             dec_system,
  input  logic             br_taken,
  input  logic             mem_ready,
  input  logic             trap_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  ctrl_state_t state_q, state_d;
  logic reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q, jump_q;
  logic take_q, take_d;
  logic halted_q;
  logic [1:0] cause_q;
  logic retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      take_q       <= 1'b0;
      halted_q     <= 1'b0;
      cause_q      <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      take_q  <= take_d;
      if (state_q == DECODE) begin
        reg_write_q  <= dec_reg_write;
        mem_read_q   <= dec_mem_read;
        mem_write_q  <= dec_mem_write;
        mem_to_reg_q <= dec_mem_to_reg;
        branch_q     <= dec_branch;
        jump_q       <= dec_jump;
        if (dec_illegal) begin
          halted_q <= 1'b1;
          cause_q  <= TRAP_ILLEGAL;
        end else if (dec_system) begin
          halted_q <= 1'b1;
          cause_q  <= TRAP_SYSTEM;
        end
      end
      if (state_q == TRAP && trap_ack) begin
        halted_q <= 1'b0;
        cause_q  <= TRAP_NONE;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    take_d       = take_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;

    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_illegal || dec_system) begin
          state_d = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Branches retire here, so the fresh compare result steers pc_sel this cycle.
        take_d = jump_q | (branch_q & br_taken);
        if (mem_read_q || mem_write_q) begin
          state_d = MEM;
        end else if (reg_write_q) begin
          state_d = WB;
        end else begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_write_q;
        if (mem_ready) begin
          if (mem_read_q) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        wb_sel  = mem_to_reg_q ? WB_SEL_MEM : (jump_q ? WB_SEL_PC4 : WB_SEL_ALU);
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        if (trap_ack) begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_TRAP;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (retire) begin
      pc_we  = 1'b1;
      pc_sel = take_d ? PC_SEL_TARGET : PC_SEL_PLUS4;
    end

    // Reset must silence the port immediately, even though state already reads FETCH.
    if (!rst_n) begin
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_SEL_PLUS4;
      rf_we        = 1'b0;
      wb_sel       = WB_SEL_ALU;
    end
  end

  instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (retire),
    .count(instret)
  );

  assign halted     = halted_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second 2-bit-counter instance exercises instret wrap.
module tb_multicycle_ctrl;
  import rvnova_ctrl_pkg::*;

  logic clk, rst_n;
  logic dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic dec_branch, dec_jump, dec_illegal, dec_system;
  logic br_taken, mem_ready, trap_ack;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, halted;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  logic s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_we, s_pc_we, s_rf_we, s_halted;
  logic [1:0] s_pc_sel, s_wb_sel, s_trap_cause;
  logic [1:0] s_instret;

  logic [9:0] outs;
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel};

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
    .dec_branch(dec_branch), .dec_jump(dec_jump),
    .dec_illegal(dec_illegal), .dec_system(dec_system),
    .br_taken(br_taken), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .halted(halted), .trap_cause(trap_cause), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
    .dec_branch(dec_branch), .dec_jump(dec_jump),
    .dec_illegal(dec_illegal), .dec_system(dec_system),
    .br_taken(br_taken), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr_sel(s_mem_addr_sel), .ir_we(s_ir_we),
    .pc_we(s_pc_we), .pc_sel(s_pc_sel), .rf_we(s_rf_we), .wb_sel(s_wb_sel),
    .halted(s_halted), .trap_cause(s_trap_cause), .instret(s_instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] pk(input logic req, input logic we, input logic asel,
                                    input logic ir, input logic pcwe, input logic [1:0] pcsel,
                                    input logic rfwe, input logic [1:0] wbsel);
    return {req, we, asel, ir, pcwe, pcsel, rfwe, wbsel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here hold for the whole cycle.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_dec(input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic br, input logic jmp, input logic ill, input logic sys);
    dec_reg_write  = rw;
    dec_mem_read   = mr;
    dec_mem_write  = mw;
    dec_mem_to_reg = m2r;
    dec_branch     = br;
    dec_jump       = jmp;
    dec_illegal    = ill;
    dec_system     = sys;
  endtask

  localparam logic [9:0] Idle = 10'b0;

  initial begin
    rst_n = 1'b0;
    br_taken = 1'b0;
    mem_ready = 1'b1;
    trap_ack = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    #1 chk("rst.outs", outs, Idle);
    chk("rst.instret", instret, 0);
    chk("rst.halted", halted, 0);
    chk("rst.cause", trap_cause, TRAP_NONE);
    nxt();
    nxt();

    // R-type: FETCH DECODE EXEC WB
    rst_n = 1'b1;
    set_dec(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rt.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); #1 chk("rt.decode", outs, Idle);
    nxt(); #1 chk("rt.exec", outs, Idle);
    nxt(); #1 chk("rt.wb", outs, pk(0, 0, 0, 0, 1, PC_SEL_PLUS4, 1, WB_SEL_ALU));
    chk("rt.instret_pre", instret, 0);

    // Load with two wait states in FETCH and MEM
    nxt();
    set_dec(1, 1, 0, 1, 0, 0, 0, 0);
    mem_ready = 1'b0;
    #1 chk("ld.f1", outs, pk(1, 0, 0, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("rt.instret", instret, 1);
    nxt(); #1 chk("ld.f2", outs, pk(1, 0, 0, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); mem_ready = 1'b1;
    #1 chk("ld.f3", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); #1 chk("ld.decode", outs, Idle);
    nxt(); #1 chk("ld.exec", outs, Idle);
    nxt(); mem_ready = 1'b0;
    #1 chk("ld.m1", outs, pk(1, 0, 1, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); #1 chk("ld.m2", outs, pk(1, 0, 1, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); mem_ready = 1'b1;
    #1 chk("ld.m3", outs, pk(1, 0, 1, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); #1 chk("ld.wb", outs, pk(0, 0, 0, 0, 1, PC_SEL_PLUS4, 1, WB_SEL_MEM));

    // Store
    nxt();
    set_dec(0, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("st.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("ld.instret", instret, 2);
    chk("small.instret2", s_instret, 2);
    nxt(); #1 chk("st.decode", outs, Idle);
    nxt(); #1 chk("st.exec", outs, Idle);
    nxt(); #1 chk("st.mem", outs, pk(1, 1, 1, 0, 1, PC_SEL_PLUS4, 0, WB_SEL_ALU));

    // Branch taken
    nxt();
    set_dec(0, 0, 0, 0, 1, 0, 0, 0);
    br_taken = 1'b1;
    #1 chk("bt.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("st.instret", instret, 3);
    chk("small.instret3", s_instret, 3);
    nxt(); #1 chk("bt.decode", outs, Idle);
    nxt(); #1 chk("bt.exec", outs, pk(0, 0, 0, 0, 1, PC_SEL_TARGET, 0, WB_SEL_ALU));

    // Branch not taken
    nxt();
    br_taken = 1'b0;
    #1 chk("bn.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("bt.instret", instret, 4);
    chk("small.wrap", s_instret, 0);
    nxt(); #1 chk("bn.decode", outs, Idle);
    nxt(); #1 chk("bn.exec", outs, pk(0, 0, 0, 0, 1, PC_SEL_PLUS4, 0, WB_SEL_ALU));

    // JAL
    nxt();
    set_dec(1, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("jal.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("bn.instret", instret, 5);
    nxt(); #1 chk("jal.decode", outs, Idle);
    nxt(); #1 chk("jal.exec", outs, Idle);
    nxt(); #1 chk("jal.wb", outs, pk(0, 0, 0, 0, 1, PC_SEL_TARGET, 1, WB_SEL_PC4));

    // Illegal + system: illegal wins
    nxt();
    set_dec(0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("ill.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("jal.instret", instret, 6);
    nxt(); #1 chk("ill.decode", outs, Idle);
    chk("ill.decode_halted", halted, 0);
    nxt();
    #1 chk("ill.halted", halted, 1);
    chk("ill.cause", trap_cause, TRAP_ILLEGAL);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      #1 chk($sformatf("ill.trap%0d", i), outs, Idle);
    end
    nxt();
    trap_ack = 1'b1;
    #1 chk("ill.ack", outs, pk(0, 0, 0, 0, 1, PC_SEL_TRAP, 0, WB_SEL_ALU));
    chk("ill.ack_halted", halted, 1);
    chk("ill.instret", instret, 6);

    // trap_ack lingering in FETCH is ignored
    nxt();
    mem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("ack.fetch_ignored", outs, pk(1, 0, 0, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("ack.halted_clr", halted, 0);
    chk("ack.cause_clr", trap_cause, TRAP_NONE);

    // ECALL alone
    nxt();
    trap_ack = 1'b0;
    mem_ready = 1'b1;
    #1 chk("sys.fetch", outs, pk(1, 0, 0, 1, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    nxt(); #1 chk("sys.decode", outs, Idle);
    nxt(); #1 chk("sys.cause", trap_cause, TRAP_SYSTEM);
    chk("sys.trap", outs, Idle);
    nxt();
    trap_ack = 1'b1;
    #1 chk("sys.ack", outs, pk(0, 0, 0, 0, 1, PC_SEL_TRAP, 0, WB_SEL_ALU));

    // Store interrupted by reset while waiting in MEM
    nxt();
    trap_ack = 1'b0;
    set_dec(0, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("sys.instret", instret, 6);
    chk("sys.halted_clr", halted, 0);
    nxt(); #1 chk("rm.decode", outs, Idle);
    nxt(); #1 chk("rm.exec", outs, Idle);
    nxt();
    mem_ready = 1'b0;
    #1 chk("rm.mem", outs, pk(1, 1, 1, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    #1 rst_n = 1'b0;
    #1 chk("rm.req_drop", outs, Idle);
    chk("rm.instret", instret, 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rm.fetch", outs, pk(1, 0, 0, 0, 0, PC_SEL_PLUS4, 0, WB_SEL_ALU));
    chk("rm.instret_after", instret, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
